mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit forming the memory stage directly downstream of the 64-bit execute ALU. Consumes the ALU result as an effective address (or passes it through for non-memory ops) and drives a single-outstanding req/ack data-memory port. Handles byte alignment, store byte masks, and load sign/zero extension. Produces one registered write-back beat per accepted op.

## Interface
- Parameters: none; data path fixed at 64 bits, 8-byte memory words.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: upstream op valid.
- `ex_ready` out 1: unit can accept; transfer when `ex_valid && ex_ready`.
- `ex_res` in 64: ALU result; address for memory ops, write-back value otherwise.
- `ex_rs2` in 64: store data.
- `ex_mem_op` in 3: funct3 encoding. 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 illegal.
- `ex_mem_re` in 1: load.
- `ex_mem_we` in 1: store.
- `ex_rd` in 5: destination register.
- `ex_reg_we` in 1: register write enable for non-memory ops.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 64: `{addr[63:3],3'b000}`.
- `mem_wdata` out 64: lane-shifted store data.
- `mem_wmask` out 8: byte enables.
- `mem_rdata` in 64: load data, valid with ack.
- `mem_ack` in 1: request complete.
- `wb_valid` out 1: one-cycle write-back pulse.
- `wb_rd` out 5: destination register.
- `wb_we` out 1: register write enable.
- `wb_data` out 64: write-back value.
- `wb_fault` out 1: misaligned or illegal access.

## Operation
- **States:** IDLE, MEM.
  - `ex_ready = (state==IDLE)`.
- **Non-memory op accepted** (`re=we=0`): next cycle `wb_valid=1`, `wb_data=ex_res`, `wb_we=ex_reg_we`. State stays IDLE, giving full throughput.
- **Fault check at accept:**
  - A fault is any of: `mem_op=111`; `re&&we`; `wu`/`bu`/`hu` with `we`; h/hu with `addr[0]!=0`; w/wu with `addr[1:0]!=0`; d with `addr[2:0]!=0`.
  - On fault: no memory request. Next cycle `wb_valid=1`, `wb_fault=1`, `wb_we=0`, `wb_data=ex_res` (the faulting address). State stays IDLE.
- **Legal memory op accepted:** latch the op and go to MEM. `mem_req=1` from the next cycle until the cycle `mem_ack=1`, inclusive. `mem_addr`, `mem_we`, `mem_wdata` and `mem_wmask` are stable while `mem_req=1`.
- **Store lanes:**
  - Offset `o = addr[2:0]`.
  - `mem_wdata = ex_rs2 << (8*o)`, with low bytes replicated as the size requires.
  - `mem_wmask` is 0x01/0x03/0x0F/0xFF for b/h/w/d, shifted left by `o`.
- **Load extract:** `(mem_rdata >> 8*o)`, truncated to size. b/h/w are sign-extended; bu/hu/wu are zero-extended; d is unchanged.
- **On `mem_ack` in MEM:**
  - Capture the result and go to IDLE.
  - Next cycle `wb_valid=1`.
  - Load: `wb_we=1`, `wb_data` = extended data.
  - Store: `wb_we=0`, `wb_data=0`.
- **Ignored conditions:**
  - `mem_ack` while in IDLE.
  - No write-back backpressure: `wb_valid` is a single-cycle pulse.
- **Write to x0:** `wb_rd=0` is passed through; the register file discards it.

## Timing
- **Reset:** state IDLE; `ex_ready=1` after reset. All other outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`, `wb_valid`, `wb_rd`, `wb_we`, `wb_data`, `wb_fault`.
- **Non-memory or fault latency:** 1 cycle, accept at T → `wb_valid` at T+1.
- **Memory latency:** accept at T, `mem_req` at T+1. If ack arrives at T+k (k≥1), `wb_valid` is at T+k+1, so the minimum is 2 cycles.
- **Next accept:** `ex_ready` re-asserts in the cycle after ack, so the next op can be accepted while the previous `wb_valid` is high.
- **Outputs:** all registered; no combinational path from `mem_ack`/`mem_rdata` to `wb_*`.
- **`rst` during MEM:** the request is abandoned, `mem_req=0` the next cycle, and no `wb_valid` is generated for it. A late `mem_ack` is ignored.
- **`rst` and `ex_valid` together:** reset wins; the op is not accepted.

## Structure
- **Package `lsu_pkg`:**
  - `mem_op` localparams: `MOP_B`…`MOP_WU`, `MOP_ILL`.
  - State enum: `S_IDLE`, `S_MEM`.
  - Size-mask constants.
- **Sub-module `lsu_align`** (combinational):
  - Store lane shift/mask generation.
  - Load extract/extend.
  - Fault detection.
- The top level holds the FSM and registers.

## Test plan
- **Non-memory passthrough:** `ex_res=0x1234`, `ex_rd=5`, `ex_reg_we=1` → next cycle `wb_valid=1`, `wb_data=0x1234`, `wb_rd=5`, `wb_we=1`, no `mem_req`. Back-to-back ops on consecutive cycles each produce a pulse.
- **lb with sign extension:** addr `0x1003`, ack after 3 cycles with `rdata=0x00000000_80000000` → `mem_addr=0x1000`, `wb_data=0xFFFF_FFFF_FFFF_FF80`, `wb_valid` 4 cycles after `mem_req` first rises. The same access as lbu → `0x80`.
- **sh store:** addr `0x2006`, `rs2=0xABCD` → `mem_wmask=0xC0`, `mem_wdata[63:48]=0xABCD`, `mem_we=1`; `wb_we=0` after ack.
- **Misaligned lw:** addr `0x3002` → no `mem_req`; next cycle `wb_fault=1`, `wb_data=0x3002`, `wb_we=0`. `mem_op=111` gives the same response.
- **Same-cycle ack:** ld at `0x4000` with ack in the first `mem_req` cycle and `rdata=0xDEADBEEF_01234567` → `wb_data` equals rdata, `wb_valid` at T+2.
- **Reset mid-op:** assert `rst` two cycles into MEM with ack withheld → `mem_req=0` next cycle, no `wb_valid`, `ex_ready=1`. A later stray `mem_ack` produces no output.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 memory-op codes, FSM states
// and the per-size byte-enable patterns.
package lsu_pkg;

    localparam logic [2:0] MOP_B   = 3'b000;
    localparam logic [2:0] MOP_H   = 3'b001;
    localparam logic [2:0] MOP_W   = 3'b010;
    localparam logic [2:0] MOP_D   = 3'b011;
    localparam logic [2:0] MOP_BU  = 3'b100;
    localparam logic [2:0] MOP_HU  = 3'b101;
    localparam logic [2:0] MOP_WU  = 3'b110;
    localparam logic [2:0] MOP_ILL = 3'b111;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEM  = 1'b1
    } state_e;

    // The low two funct3 bits give the access size for both signed and unsigned ops.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = MASK_B;
            2'b01:   size_mask = MASK_H;
            2'b10:   size_mask = MASK_W;
            default: size_mask = MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath helpers: store lane replication and byte mask,
// load extraction with sign/zero extension, and access fault detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_op_i,
    input  logic [2:0]  st_off_i,
    input  logic        st_re_i,
    input  logic        st_we_i,
    input  logic [63:0] st_rs2_i,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_wmask_o,
    output logic        st_fault_o,
    input  logic [2:0]  ld_op_i,
    input  logic [2:0]  ld_off_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [63:0] ld_shifted;
    logic        misalign;

    // Replicating the low bytes across the word places them in every lane an
    // aligned access of that size could select.
    always_comb begin
        case (st_op_i[1:0])
            2'b00:   st_wdata_o = {8{st_rs2_i[7:0]}};
            2'b01:   st_wdata_o = {4{st_rs2_i[15:0]}};
            2'b10:   st_wdata_o = {2{st_rs2_i[31:0]}};
            default: st_wdata_o = st_rs2_i;
        endcase
        st_wmask_o = size_mask(st_op_i[1:0]) << st_off_i;
    end

    always_comb begin
        case (st_op_i[1:0])
            2'b01:   misalign = st_off_i[0];
            2'b10:   misalign = |st_off_i[1:0];
            2'b11:   misalign = |st_off_i;
            default: misalign = 1'b0;
        endcase
        st_fault_o = (st_re_i | st_we_i) &
                     ((st_op_i == MOP_ILL) | (st_re_i & st_we_i) |
                      (st_we_i & st_op_i[2]) | misalign);
    end

    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_op_i[1:0])
            2'b00:   ld_data_o = ld_op_i[2] ? {56'd0, ld_shifted[7:0]}
                                            : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01:   ld_data_o = ld_op_i[2] ? {48'd0, ld_shifted[15:0]}
                                            : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            2'b10:   ld_data_o = ld_op_i[2] ? {32'd0, ld_shifted[31:0]}
                                            : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage: accepts one op per cycle from execute, runs a single-outstanding
// req/ack data-memory access for loads/stores, and emits one registered write-back beat.
module mem_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] ex_res,
    input  logic [63:0] ex_rs2,
    input  logic [2:0]  ex_mem_op,
    input  logic        ex_mem_re,
    input  logic        ex_mem_we,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [63:0] wb_data,
    output logic        wb_fault,
    output state_e      dbg_state
);

    // Handshake: an op transfers on a rising edge where ex_valid && ex_ready;
    // ex_ready depends only on state. The memory port holds mem_req and all its
    // payload stable until the edge that samples mem_ack high; wb_valid is a
    // single-cycle pulse with no backpressure.

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  off_q, off_d;
    logic        req_q, req_d;
    logic        mwe_q, mwe_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        wbv_q, wbv_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic        wbwe_q, wbwe_d;
    logic [63:0] wbdata_q, wbdata_d;
    logic        wbflt_q, wbflt_d;

    logic [63:0] st_wdata;
    logic [7:0]  st_wmask;
    logic        st_fault;
    logic [63:0] ld_data;

    lsu_align u_align (
        .st_op_i    (ex_mem_op),
        .st_off_i   (ex_res[2:0]),
        .st_re_i    (ex_mem_re),
        .st_we_i    (ex_mem_we),
        .st_rs2_i   (ex_rs2),
        .st_wdata_o (st_wdata),
        .st_wmask_o (st_wmask),
        .st_fault_o (st_fault),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (mem_rdata),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        req_d    = req_q;
        mwe_d    = mwe_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        wbv_d    = 1'b0;
        wbrd_d   = wbrd_q;
        wbwe_d   = wbwe_q;
        wbdata_d = wbdata_q;
        wbflt_d  = wbflt_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    wbrd_d = ex_rd;
                    if (!ex_mem_re && !ex_mem_we) begin
                        wbv_d    = 1'b1;
                        wbwe_d   = ex_reg_we;
                        wbdata_d = ex_res;
                        wbflt_d  = 1'b0;
                    end else if (st_fault) begin
                        wbv_d    = 1'b1;
                        wbwe_d   = 1'b0;
                        wbdata_d = ex_res;
                        wbflt_d  = 1'b1;
                    end else begin
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        op_d    = ex_mem_op;
                        off_d   = ex_res[2:0];
                        mwe_d   = ex_mem_we;
                        addr_d  = {ex_res[63:3], 3'b000};
                        wdata_d = ex_mem_we ? st_wdata : 64'd0;
                        wmask_d = ex_mem_we ? st_wmask : 8'd0;
                    end
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d  = S_IDLE;
                    req_d    = 1'b0;
                    wbv_d    = 1'b1;
                    wbwe_d   = !mwe_q;
                    wbdata_d = mwe_q ? 64'd0 : ld_data;
                    wbflt_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            off_q    <= 3'd0;
            req_q    <= 1'b0;
            mwe_q    <= 1'b0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            wmask_q  <= 8'd0;
            wbv_q    <= 1'b0;
            wbrd_q   <= 5'd0;
            wbwe_q   <= 1'b0;
            wbdata_q <= 64'd0;
            wbflt_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            off_q    <= off_d;
            req_q    <= req_d;
            mwe_q    <= mwe_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            wbv_q    <= wbv_d;
            wbrd_q   <= wbrd_d;
            wbwe_q   <= wbwe_d;
            wbdata_q <= wbdata_d;
            wbflt_q  <= wbflt_d;
        end
    end

    assign ex_ready  = (state_q == S_IDLE);
    assign mem_req   = req_q;
    assign mem_we    = mwe_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign wb_valid  = wbv_q;
    assign wb_rd     = wbrd_q;
    assign wb_we     = wbwe_q;
    assign wb_data   = wbdata_q;
    assign wb_fault  = wbflt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus a random op mix, with write-back
// beats checked against an expected queue filled when each op is driven.
module tb_mem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [63:0] ex_res = '0;
    logic [63:0] ex_rs2 = '0;
    logic [2:0]  ex_mem_op = '0;
    logic        ex_mem_re = 1'b0;
    logic        ex_mem_we = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_we = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [63:0] wb_data;
    logic        wb_fault;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [70:0] exp_q[$];
    logic [70:0] mon_e;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_res(ex_res), .ex_rs2(ex_rs2), .ex_mem_op(ex_mem_op),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .wb_fault(wb_fault),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write-back pulse must match the oldest expected beat.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_beat", {wb_fault, wb_we, wb_rd, wb_data}, mon_e);
            end
        end
    end

    function automatic logic [7:0] exp_mask(input logic [2:0] op, input logic [2:0] off);
        int nb;
        nb = 1 << op[1:0];
        for (int i = 0; i < 8; i++) exp_mask[i] = (i >= off) && (i < off + nb);
    endfunction

    function automatic logic [63:0] lane_bits(input logic [7:0] m);
        for (int i = 0; i < 8; i++) lane_bits[8*i +: 8] = {8{m[i]}};
    endfunction

    function automatic logic [63:0] exp_lanes(input logic [63:0] rs2, input logic [2:0] op, input logic [2:0] off);
        logic [7:0] m;
        m = exp_mask(op, off);
        exp_lanes = '0;
        for (int i = 0; i < 8; i++)
            if (m[i]) exp_lanes[8*i +: 8] = rs2[8*(i - off) +: 8];
    endfunction

    function automatic logic [63:0] exp_load(input logic [2:0] op, input logic [2:0] off, input logic [63:0] rd);
        int nb;
        nb = 1 << op[1:0];
        exp_load = '0;
        for (int i = 0; i < nb; i++) exp_load[8*i +: 8] = rd[8*(off + i) +: 8];
        if (!op[2] && nb < 8 && exp_load[8*nb-1])
            for (int i = 8*nb; i < 64; i++) exp_load[i] = 1'b1;
    endfunction

    function automatic logic pred_fault(input logic [2:0] op, input logic re, input logic we, input logic [63:0] a);
        int nb;
        nb = 1 << op[1:0];
        pred_fault = (op == 3'b111) || (re && we) || (we && op[2]) || ((a % nb) != 0);
    endfunction

    task automatic issue(input logic [63:0] res, input logic [63:0] rs2, input logic [2:0] op,
                         input logic re, input logic we, input logic [4:0] rd, input logic rwe);
        int n;
        n = 0;
        while (!ex_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!ex_ready) chk("ready_timeout", 0, 1);
        ex_valid = 1'b1; ex_res = res; ex_rs2 = rs2; ex_mem_op = op;
        ex_mem_re = re; ex_mem_we = we; ex_rd = rd; ex_reg_we = rwe;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic serve(input int dly, input logic [63:0] rdata, input logic [63:0] addr,
                         input logic we, input logic [7:0] m, input logic [63:0] lanes);
        for (int c = 0; c <= dly; c++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, {addr[63:3], 3'b000});
            chk("mem_we", mem_we, we);
            if (we) begin
                chk("mem_wmask", mem_wmask, m);
                chk("mem_wdata", mem_wdata & lane_bits(m), lanes);
            end
            if (c == dly) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; mem_rdata = '0;
        chk("req_drop", mem_req, 0);
        chk("wb_lat_mem", wb_valid, 1);
    endtask

    task automatic do_op(input logic [63:0] res, input logic [63:0] rs2, input logic [2:0] op,
                         input logic re, input logic we, input logic [4:0] rd, input logic rwe,
                         input int dly, input logic [63:0] rdata);
        logic [2:0] off;
        off = res[2:0];
        if (!re && !we) begin
            exp_q.push_back({1'b0, rwe, rd, res});
            issue(res, rs2, op, re, we, rd, rwe);
            chk("wb_lat_alu", wb_valid, 1);
            chk("no_req_alu", mem_req, 0);
        end else if (pred_fault(op, re, we, res)) begin
            exp_q.push_back({1'b1, 1'b0, rd, res});
            issue(res, rs2, op, re, we, rd, rwe);
            chk("wb_lat_flt", wb_valid, 1);
            chk("no_req_flt", mem_req, 0);
        end else begin
            if (we) exp_q.push_back({1'b0, 1'b0, rd, 64'd0});
            else    exp_q.push_back({1'b0, 1'b1, rd, exp_load(op, off, rdata)});
            issue(res, rs2, op, re, we, rd, rwe);
            serve(dly, rdata, res, we, exp_mask(op, off), exp_lanes(rs2, op, off));
        end
    endtask

    initial begin
        logic [63:0] a, d, r;
        logic [2:0]  op;
        int          kind, nb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ex_ready, 1);
        chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask}, 0);
        chk("rst_wb", {wb_valid, wb_rd, wb_we, wb_data, wb_fault}, 0);

        // Reset and a valid op in the same cycle: the op must be dropped.
        ex_valid = 1'b1; ex_res = 64'h77; ex_rd = 5'd3; ex_reg_we = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0;
        chk("rst_vs_valid", wb_valid, 0);
        @(posedge clk); #1;
        chk("rst_vs_valid2", wb_valid, 0);

        do_op(64'h1234, 0, 3'b000, 0, 0, 5'd5, 1, 0, 0);
        chk("alu_data", {wb_rd, wb_we, wb_data}, {5'd5, 1'b1, 64'h1234});
        do_op(64'hCAFE, 0, 3'b000, 0, 0, 5'd0, 1, 0, 0);
        do_op(64'hBEEF, 0, 3'b000, 0, 0, 5'd7, 0, 0, 0);

        do_op(64'h1003, 0, MOP_B, 1, 0, 5'd9, 0, 3, 64'h00000000_80000000);
        chk("lb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(64'h1003, 0, MOP_BU, 1, 0, 5'd9, 0, 3, 64'h00000000_80000000);
        chk("lbu_data", wb_data, 64'h80);

        do_op(64'h2006, 64'hABCD, MOP_H, 0, 1, 5'd4, 0, 1, 0);
        chk("sh_wb", {wb_we, wb_data}, 0);

        do_op(64'h3002, 0, MOP_W, 1, 0, 5'd6, 0, 0, 0);
        chk("lw_fault", {wb_fault, wb_we, wb_data}, {1'b1, 1'b0, 64'h3002});
        do_op(64'h3000, 0, MOP_ILL, 1, 0, 5'd6, 0, 0, 0);
        chk("ill_fault", wb_fault, 1);

        do_op(64'h4000, 0, MOP_D, 1, 0, 5'd10, 0, 0, 64'hDEADBEEF_01234567);
        chk("ld_data", wb_data, 64'hDEADBEEF_01234567);

        // Reset two cycles into MEM with ack withheld, then a stray ack.
        issue(64'h5000, 0, MOP_D, 1, 0, 5'd11, 0);
        chk("mid_req", mem_req, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_ready", ex_ready, 1);
        chk("mid_rst_wb", wb_valid, 0);
        mem_ack = 1'b1; mem_rdata = 64'h1111;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        chk("stray_ack_wb", wb_valid, 0);
        @(posedge clk); #1;
        chk("stray_ack_wb2", {wb_valid, mem_req}, 0);

        for (int n = 0; n < 40; n++) begin
            op   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 4);
            nb   = 1 << op[1:0];
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
            d = {$urandom, $urandom};
            r = {$urandom, $urandom};
            case (kind)
                0:       do_op(a, d, op, 0, 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0);
                1, 2:    do_op(a, d, op, 1, 0, 5'($urandom_range(0, 31)), 0, $urandom_range(0, 3), r);
                3:       do_op(a, d, op, 0, 1, 5'($urandom_range(0, 31)), 0, $urandom_range(0, 3), r);
                default: do_op(a, d, op, 1, 1, 5'($urandom_range(0, 31)), 0, 0, r);
            endcase
        end

        repeat (3) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
